// File: rtl/alu_issue_ctrl_if.sv
// Purpose: bundles the decode-side request, the ALU operand/result bus and the response channel.
// Latency: none; wiring only.
// Backpressure: valid/ready on both request (in_*) and response (out_*) channels.
// Ports: master = requester/ALU side (testbench), slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 4
);
    // request channel
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    // ALU bus
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [CTRL_WIDTH-1:0] Alu_control;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    // response channel
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_branch;
    logic                  out_overflow;
    logic                  out_illegal;

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm,
        input  in_ready,
        input  alu_a, alu_b, Alu_control,
        output alu_result, alu_zero, alu_overflow,
        input  out_valid, out_result, out_branch, out_overflow, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm,
        output in_ready,
        output alu_a, alu_b, Alu_control,
        input  alu_result, alu_zero, alu_overflow,
        output out_valid, out_result, out_branch, out_overflow, out_illegal,
        input  out_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue FSM that decodes one RV64 ALU/LD/SD/BEQ instruction, drives the external ALU and returns a response.
// Latency: accept edge E0; legal response valid after E2, illegal after E1; >= 4 cycles per legal op.
// Backpressure: in_ready only in IDLE; response held stable in RESP until out_ready.
// Ports: clk, rst_n (async, active low), bus (slave modport of alu_issue_ctrl_if), retired_cnt (legal responses accepted).
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      bus,
    output logic [CNT_WIDTH-1:0] retired_cnt
);
    localparam logic [CTRL_WIDTH-1:0] CTRL_ADD  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_SUB  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_AND  = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] CTRL_OR   = CTRL_WIDTH'(3);
    // all-ones code parks the ALU with a zero output between operations
    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE = {CTRL_WIDTH{1'b1}};

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

    state_t state_q, state_d;

    logic [6:0]            opcode_q;
    logic [2:0]            funct3_q;
    logic                  funct7_5_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q, imm_q;

    logic                  dec_legal, dec_use_imm, dec_ovf_en, dec_branch;
    logic [CTRL_WIDTH-1:0] dec_ctrl;

    // Decode works on the latched fields, so it stays valid through DECODE and EXEC.
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_ovf_en  = 1'b0;
        dec_branch  = 1'b0;
        dec_ctrl    = CTRL_ADD;
        case (opcode_q)
            OP_R: begin
                if (funct3_q == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_ovf_en = 1'b1;
                    dec_ctrl   = funct7_5_q ? CTRL_SUB : CTRL_ADD;
                end else if (funct3_q == 3'b111 && !funct7_5_q) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_AND;
                end else if (funct3_q == 3'b110 && !funct7_5_q) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_OR;
                end
            end
            // bit 30 belongs to the immediate here, so it does not qualify the op
            OP_I: begin
                dec_use_imm = 1'b1;
                if (funct3_q == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_ovf_en = 1'b1;
                    dec_ctrl   = CTRL_ADD;
                end else if (funct3_q == 3'b111) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_AND;
                end else if (funct3_q == 3'b110) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_OR;
                end
            end
            // address generation: overflow is meaningless for an address
            OP_LD, OP_SD: begin
                dec_use_imm = 1'b1;
                dec_legal   = (funct3_q == 3'b011);
                dec_ctrl    = CTRL_ADD;
            end
            OP_BR: begin
                dec_legal  = (funct3_q == 3'b000);
                dec_branch = 1'b1;
                dec_ctrl   = CTRL_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = DECODE;
            DECODE:  state_d = dec_legal ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q         <= '0;
            funct3_q         <= '0;
            funct7_5_q       <= 1'b0;
            rs1_q            <= '0;
            rs2_q            <= '0;
            imm_q            <= '0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.Alu_control  <= CTRL_IDLE;
            bus.out_result   <= '0;
            bus.out_branch   <= 1'b0;
            bus.out_overflow <= 1'b0;
            bus.out_illegal  <= 1'b0;
            retired_cnt      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opcode_q   <= bus.opcode;
                        funct3_q   <= bus.funct3;
                        funct7_5_q <= bus.funct7_5;
                        rs1_q      <= bus.rs1_data;
                        rs2_q      <= bus.rs2_data;
                        imm_q      <= bus.imm;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        bus.alu_a       <= rs1_q;
                        bus.alu_b       <= dec_use_imm ? imm_q : rs2_q;
                        bus.Alu_control <= dec_ctrl;
                    end else begin
                        bus.out_result   <= '0;
                        bus.out_branch   <= 1'b0;
                        bus.out_overflow <= 1'b0;
                        bus.out_illegal  <= 1'b1;
                    end
                end
                EXEC: begin
                    bus.out_result   <= bus.alu_result;
                    bus.out_branch   <= dec_branch & bus.alu_zero;
                    bus.out_overflow <= dec_ovf_en & bus.alu_overflow;
                    bus.out_illegal  <= 1'b0;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.Alu_control <= CTRL_IDLE;
                        if (!bus.out_illegal) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
